sram_cache_controller: RTL and testbench

- 2-way set-associative, write-through, no-write-allocate read cache between the MEM stage and the SRAM controller.
- Read hits complete in the same cycle without touching SRAM.
- Read misses fetch a 64-bit block (two words) from the SRAM controller.
- Writes always go through to SRAM. The MEM stage stalls on ready=0 exactly as it does for the bare SRAM controller.

---
 rtl/sram_cache_controller.sv | 166 ++++++++++++++++
 tb/tb_sram_cache_controller.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sram_cache_controller.sv
// sram_cache_controller
//   2-way set-associative, write-through, no-write-allocate read cache that
//   sits between the MEM stage and the SRAM controller. Read hits return in
//   the same cycle. Read misses fetch a 64-bit block (two words). Writes go
//   straight through to SRAM and invalidate any cached copy.
//
// Ports
//   clk, rst          clock (rising edge) / synchronous active-low reset
//   mem_read/write    request from MEM stage (both high = write)
//   address, wdata    byte address (word aligned) and store data
//   rdata, ready      load result / 0 = stall the pipeline
//   sram_rd_en        block read request to the SRAM controller
//   sram_wr_en        word write request to the SRAM controller
//   sram_address      address to SRAM (un-offset; block aligned for reads)
//   sram_wdata        store data to SRAM
//   sram_rdata        returned block, word0 in [31:0], word1 in [63:32]
//   sram_ready        one-cycle completion pulse from the SRAM controller
module sram_cache_controller #(
  parameter int SETS      = 64,
  parameter int TAG_W     = 10,
  parameter int BASE_ADDR = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        sram_rd_en,
  output logic        sram_wr_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  input  logic [63:0] sram_rdata,
  input  logic        sram_ready
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_LO = 3 + IDX_W;

  typedef enum logic [1:0] {IDLE, READ_MISS, WRITE_THRU} state_t;

  state_t state;

  // Address decode, relative to the data-memory base
  logic [31:0]      a;
  logic             wsel;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;

  assign a    = address - 32'(BASE_ADDR);
  assign wsel = a[2];
  assign idx  = a[TAG_LO-1:3];
  assign tag  = a[TAG_LO +: TAG_W];

  // Byte offset and bits above the tag do not take part in the lookup
  logic unused_addr;
  assign unused_addr = ^{a[31:TAG_LO+TAG_W], a[1:0]};

  // Per-way storage: valid/LRU are reset, tag/data arrays are plain RAM
  logic [SETS-1:0]  valid [2];
  logic [SETS-1:0]  lru;
  logic [TAG_W-1:0] tag_mem  [2][SETS];
  logic [63:0]      data_mem [2][SETS];

  logic       is_wr, is_rd;
  logic [1:0] hit;
  logic       hit_any, hit_way, victim;
  logic [63:0] hit_blk;

  assign is_wr = mem_write;
  assign is_rd = mem_read & ~mem_write;

  always_comb begin
    for (int w = 0; w < 2; w++)
      hit[w] = valid[w][idx] && (tag_mem[w][idx] == tag);
    hit_any = |hit;
    hit_way = hit[1] & ~hit[0];
    hit_blk = data_mem[hit_way][idx];
    // Fill into the first empty way before evicting the LRU one
    if (!valid[0][idx])      victim = 1'b0;
    else if (!valid[1][idx]) victim = 1'b1;
    else                     victim = lru[idx];
  end

  // Combinational handshake back to the MEM stage
  always_comb begin
    ready = 1'b1;
    rdata = '0;
    case (state)
      IDLE: begin
        if (is_wr) ready = 1'b0;
        else if (is_rd) begin
          if (hit_any) rdata = wsel ? hit_blk[63:32] : hit_blk[31:0];
          else         ready = 1'b0;
        end
      end
      READ_MISS: begin
        ready = sram_ready;
        if (sram_ready) rdata = wsel ? sram_rdata[63:32] : sram_rdata[31:0];
      end
      WRITE_THRU: ready = sram_ready;
      default:    ready = 1'b1;
    endcase
  end

  // Control FSM, valid and LRU state
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      sram_rd_en   <= 1'b0;
      sram_wr_en   <= 1'b0;
      sram_address <= '0;
      sram_wdata   <= '0;
      valid[0]     <= '0;
      valid[1]     <= '0;
      lru          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_wr) begin
            sram_wr_en   <= 1'b1;
            sram_address <= address;
            sram_wdata   <= wdata;
            state        <= WRITE_THRU;
            // Stale copy is dropped rather than updated
            if (hit[0]) valid[0][idx] <= 1'b0;
            if (hit[1]) valid[1][idx] <= 1'b0;
          end else if (is_rd) begin
            if (hit_any) lru[idx] <= ~hit_way;
            else begin
              sram_rd_en   <= 1'b1;
              sram_address <= {address[31:3], 3'b000};
              state        <= READ_MISS;
            end
          end
        end
        READ_MISS: begin
          if (sram_ready) begin
            sram_rd_en         <= 1'b0;
            valid[victim][idx] <= 1'b1;
            lru[idx]           <= ~victim;
            state              <= IDLE;
          end
        end
        WRITE_THRU: begin
          if (sram_ready) begin
            sram_wr_en <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line fill; a reset in the same cycle abandons the fill
  always_ff @(posedge clk) begin
    if (rst && state == READ_MISS && sram_ready) begin
      tag_mem[victim][idx]  <= tag;
      data_mem[victim][idx] <= sram_rdata;
    end
  end

endmodule

// File: tb/tb_sram_cache_controller.sv
module tb_sram_cache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [31:0] address, wdata, rdata;
  logic        ready;
  logic        sram_rd_en, sram_wr_en;
  logic [31:0] sram_address, sram_wdata;
  logic [63:0] sram_rdata;
  logic        sram_ready;

  int n_chk  = 0;
  int n_fail = 0;
  int stalls;

  always #5 clk = ~clk;

  sram_cache_controller #(.SETS(64), .TAG_W(10), .BASE_ADDR(1024)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .wdata(wdata),
    .rdata(rdata), .ready(ready),
    .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en),
    .sram_address(sram_address), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .sram_ready(sram_ready)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Load; for a miss the SRAM answers after waitc READ_MISS cycles with blk
  task automatic ld(input logic [31:0] addr, input logic hit, input logic [63:0] blk,
                    input logic [31:0] exp, input int waitc, output int nstall);
    nstall = 0;
    @(posedge clk); #1;
    mem_read = 1'b1; mem_write = 1'b0; address = addr;
    #1;
    if (hit) begin
      chk("ld_hit_rdy", ready, 1);
      chk("ld_hit_data", rdata, exp);
      chk("ld_hit_rden", sram_rd_en, 0);
      @(posedge clk); #1;
      mem_read = 1'b0;
      #1;
      chk("ld_hit_norden", sram_rd_en, 0);
    end else begin
      chk("ld_miss_rdy", ready, 0);
      if (!ready) nstall++;
      @(posedge clk); #1;
      for (int i = 0; i < waitc; i++) begin
        #1;
        chk("rm_rden", sram_rd_en, 1);
        chk("rm_wren", sram_wr_en, 0);
        chk("rm_addr", sram_address, {addr[31:3], 3'b000});
        chk("rm_stall", ready, 0);
        if (!ready) nstall++;
        @(posedge clk); #1;
      end
      sram_ready = 1'b1; sram_rdata = blk;
      #1;
      chk("rm_done_rdy", ready, 1);
      chk("rm_done_data", rdata, exp);
      @(posedge clk); #1;
      sram_ready = 1'b0; mem_read = 1'b0;
      #1;
      chk("rm_after_rden", sram_rd_en, 0);
      chk("rm_after_rdy", ready, 1);
    end
  endtask

  // Store (both=1 also raises mem_read); SRAM answers after waitc cycles
  task automatic st(input logic [31:0] addr, input logic [31:0] d, input logic both,
                    input int waitc, output int nstall);
    nstall = 0;
    @(posedge clk); #1;
    mem_write = 1'b1; mem_read = both; address = addr; wdata = d;
    #1;
    chk("st_idle_rdy", ready, 0);
    if (!ready) nstall++;
    @(posedge clk); #1;
    for (int i = 0; i < waitc; i++) begin
      #1;
      chk("wt_wren", sram_wr_en, 1);
      chk("wt_rden", sram_rd_en, 0);
      chk("wt_addr", sram_address, addr);
      chk("wt_wdata", sram_wdata, d);
      chk("wt_stall", ready, 0);
      if (!ready) nstall++;
      @(posedge clk); #1;
    end
    sram_ready = 1'b1;
    #1;
    chk("wt_done_rdy", ready, 1);
    @(posedge clk); #1;
    sram_ready = 1'b0; mem_write = 1'b0; mem_read = 1'b0;
    #1;
    chk("wt_after_wren", sram_wr_en, 0);
  endtask

  initial begin
    rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    address = '0; wdata = '0; sram_rdata = '0; sram_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", ready, 1);
    chk("rst_rdata", rdata, 0);
    chk("rst_rden", sram_rd_en, 0);
    chk("rst_wren", sram_wr_en, 0);
    rst = 1'b1;

    // Basic miss then hit on the other word of the block
    ld(32'h400, 0, 64'h00000022_00000011, 32'h11, 1, stalls);
    ld(32'h404, 1, 64'h0, 32'h22, 0, stalls);

    // Same set, three tags: LRU replacement
    ld(32'h600, 0, 64'h00000066_00000055, 32'h55, 1, stalls);
    ld(32'h400, 1, 64'h0, 32'h11, 0, stalls);
    ld(32'h800, 0, 64'h00000088_00000077, 32'h77, 1, stalls);
    ld(32'h400, 1, 64'h0, 32'h11, 0, stalls);
    ld(32'h600, 0, 64'h00000066_00000055, 32'h55, 1, stalls);

    // Store to a cached line invalidates it
    st(32'h400, 32'hDEADBEEF, 0, 1, stalls);
    ld(32'h400, 0, 64'h00000022_DEADBEEF, 32'hDEADBEEF, 1, stalls);

    // Store to an uncached line does not allocate
    st(32'h1000, 32'hCAFEF00D, 0, 1, stalls);
    ld(32'h1000, 0, 64'h00000000_CAFEF00D, 32'hCAFEF00D, 1, stalls);

    // Read+write together takes the write path (0x400 becomes invalid)
    st(32'h400, 32'h12345678, 1, 1, stalls);

    // Reset in the middle of a miss, with a simultaneous sram_ready
    @(posedge clk); #1;
    mem_read = 1'b1; address = 32'h404;
    #1;
    chk("rstmid_miss", ready, 0);
    @(posedge clk); #1;
    chk("rstmid_rden", sram_rd_en, 1);
    rst = 1'b0; sram_ready = 1'b1; sram_rdata = 64'h00000022_12345678; mem_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; sram_ready = 1'b0;
    #1;
    chk("rstmid_rden0", sram_rd_en, 0);
    chk("rstmid_wren0", sram_wr_en, 0);
    chk("rstmid_rdy", ready, 1);
    ld(32'h404, 0, 64'h00000022_12345678, 32'h22, 1, stalls);

    // Slow SRAM: 5 stall cycles in total
    ld(32'h600, 0, 64'h00000066_00000055, 32'h55, 4, stalls);
    chk("slow_ld_stalls", 64'(stalls), 5);
    st(32'h1000, 32'h0BADF00D, 0, 4, stalls);
    chk("slow_st_stalls", 64'(stalls), 5);

    // Stray sram_ready while idle is ignored
    @(posedge clk); #1;
    sram_ready = 1'b1;
    #1;
    chk("stray_rdy", ready, 1);
    @(posedge clk); #1;
    sram_ready = 1'b0;
    #1;
    chk("stray_rden", sram_rd_en, 0);
    chk("stray_wren", sram_wr_en, 0);
    ld(32'h600, 1, 64'h0, 32'h55, 0, stalls);
    ld(32'h400, 1, 64'h0, 32'h12345678, 0, stalls);

    // Idle output
    @(posedge clk); #1;
    chk("idle_rdata", rdata, 0);
    chk("idle_rdy", ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  // Never both SRAM enables at once
  always @(negedge clk)
    if (sram_rd_en && sram_wr_en) chk("both_en", {sram_rd_en, sram_wr_en}, 2'b00);

endmodule
